// File: rtl/fetch_redirect_stage.sv
// IF stage: PC register, IF/ID pipeline register and redirect handling.
// Redirects flush IF/ID; misaligned targets are trapped to TRAP_VEC.
module fetch_redirect_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nextPcSrc,
  input  logic [31:0] brTarget,
  input  logic        stall,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemInst,
  output logic [31:0] ifIdInst,
  output logic [31:0] ifIdPc,
  output logic [31:0] ifIdPcInc,
  output logic        ifIdValid,
  output logic        flushIdEx,
  output logic        instMisaligned,
  output logic [31:0] misalignAddr,
  output logic [31:0] redirectCount
);

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pcInc;
    logic        valid;
  } if_id_t;

  logic [31:0] pc, pcNext, pcPlus4, tgt;
  logic [31:0] maddrNext, cntNext;
  logic        misNext;
  logic        doRedir, doHold, doStep;
  if_id_t      ifId, ifIdNext;

  assign pcPlus4   = pc + 32'd4;
  // JALR rule: bit 0 of the target is always dropped
  assign tgt       = {brTarget[31:1], 1'b0};
  assign doRedir   = nextPcSrc;
  assign doHold    = ~nextPcSrc & stall;
  assign doStep    = ~nextPcSrc & ~stall;

  assign imemAddr  = pc;
  assign flushIdEx = nextPcSrc;
  assign ifIdInst  = ifId.inst;
  assign ifIdPc    = ifId.pc;
  assign ifIdPcInc = ifId.pcInc;
  assign ifIdValid = ifId.valid;

  always_comb begin
    pcNext    = pc;
    ifIdNext  = ifId;
    misNext   = 1'b0;
    maddrNext = misalignAddr;
    cntNext   = redirectCount;
    unique case (1'b1)
      doRedir: begin
        ifIdNext = '{inst: NOP_INST, pc: '0,
                     pcInc: '0, valid: 1'b0};
        cntNext  = redirectCount + 32'd1;
        if (tgt[1]) begin
          pcNext    = TRAP_VEC;
          misNext   = 1'b1;
          maddrNext = tgt;
        end else begin
          pcNext = tgt;
        end
      end
      doHold: begin
        pcNext   = pc;
        ifIdNext = ifId;
      end
      doStep: begin
        pcNext   = pcPlus4;
        ifIdNext = '{inst: imemInst, pc: pc,
                     pcInc: pcPlus4, valid: 1'b1};
      end
      default: begin
        pcNext   = pc;
        ifIdNext = ifId;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= RESET_PC;
      ifId           <= '{inst: NOP_INST, pc: '0,
                          pcInc: '0, valid: 1'b0};
      instMisaligned <= 1'b0;
      misalignAddr   <= '0;
      redirectCount  <= '0;
    end else begin
      pc             <= pcNext;
      ifId           <= ifIdNext;
      instMisaligned <= misNext;
      misalignAddr   <= maddrNext;
      redirectCount  <= cntNext;
    end
  end

endmodule

// File: tb/tb_fetch_redirect_stage.sv
// Bench for fetch_redirect_stage: directed plan plus random traffic
// compared every cycle against a behavioural model.
module tb_fetch_redirect_stage;

  localparam logic [31:0] RPC  = 32'h0000_0000;
  localparam logic [31:0] TVEC = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        nextPcSrc = 1'b0;
  logic [31:0] brTarget = '0;
  logic        stall = 1'b0;
  logic [31:0] imemAddr, imemInst;
  logic [31:0] ifIdInst, ifIdPc, ifIdPcInc;
  logic        ifIdValid, flushIdEx, instMisaligned;
  logic [31:0] misalignAddr, redirectCount;

  int checks = 0;
  int errors = 0;

  fetch_redirect_stage #(
    .RESET_PC(RPC), .TRAP_VEC(TVEC), .NOP_INST(NOP)
  ) dut (
    .clk(clk), .rst(rst),
    .nextPcSrc(nextPcSrc), .brTarget(brTarget),
    .stall(stall),
    .imemAddr(imemAddr), .imemInst(imemInst),
    .ifIdInst(ifIdInst), .ifIdPc(ifIdPc),
    .ifIdPcInc(ifIdPcInc), .ifIdValid(ifIdValid),
    .flushIdEx(flushIdEx),
    .instMisaligned(instMisaligned),
    .misalignAddr(misalignAddr),
    .redirectCount(redirectCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a + 32'h0000_00A0;
  endfunction

  // junk on the bus whenever the word must not be captured
  assign imemInst = (stall | nextPcSrc) ? 32'hDEAD_BEEF
                                        : mem(imemAddr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // behavioural model of the architectural state
  logic [31:0] m_pc = RPC, m_inst = NOP, m_ipc = 0, m_inc = 0;
  logic [31:0] m_maddr = 0, m_cnt = 0;
  logic        m_valid = 0, m_mis = 0;

  always @(posedge clk or posedge rst) begin
    logic [31:0] t;
    if (rst) begin
      m_pc = RPC; m_inst = NOP; m_ipc = 0; m_inc = 0;
      m_valid = 0; m_mis = 0; m_maddr = 0; m_cnt = 0;
    end else if (nextPcSrc) begin
      t = brTarget & ~32'd1;
      m_mis = (t % 4) != 0;
      if (m_mis) begin
        m_pc = TVEC;
        m_maddr = t;
      end else m_pc = t;
      m_inst = NOP; m_ipc = 0; m_inc = 0; m_valid = 0;
      m_cnt = m_cnt + 1;
    end else begin
      m_mis = 0;
      if (!stall) begin
        m_inst = mem(m_pc);
        m_ipc = m_pc;
        m_inc = m_pc + 4;
        m_valid = 1;
        m_pc = m_pc + 4;
      end
    end
  end

  always @(negedge clk) begin
    chk("imemAddr", imemAddr, m_pc);
    chk("flushIdEx", {31'd0, flushIdEx}, {31'd0, nextPcSrc});
    chk("ifIdInst", ifIdInst, m_inst);
    chk("ifIdPc", ifIdPc, m_ipc);
    chk("ifIdPcInc", ifIdPcInc, m_inc);
    chk("ifIdValid", {31'd0, ifIdValid}, {31'd0, m_valid});
    chk("instMisaligned", {31'd0, instMisaligned},
        {31'd0, m_mis});
    chk("misalignAddr", misalignAddr, m_maddr);
    chk("redirectCount", redirectCount, m_cnt);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] t,
                       input logic s);
    nextPcSrc = r;
    brTarget  = t;
    stall     = s;
  endtask

  initial begin
    #1 rst = 1'b1;
    cyc();
    cyc();
    chk("rst pc", imemAddr, RPC);
    chk("rst inst", ifIdInst, NOP);
    chk("rst valid", {31'd0, ifIdValid}, 32'd0);
    chk("rst cnt", redirectCount, 32'd0);
    rst = 1'b0;
    // 1: sequential fetch
    cyc();
    chk("t1 addr4", imemAddr, 32'd4);
    chk("t1 ifIdPc0", ifIdPc, 32'd0);
    chk("t1 inst", ifIdInst, 32'hA0);
    chk("t1 valid", {31'd0, ifIdValid}, 32'd1);
    cyc();
    chk("t1 addr8", imemAddr, 32'd8);
    chk("t1 ifIdPc4", ifIdPc, 32'd4);
    // 2: stall three cycles
    drive(1'b0, 32'd0, 1'b1);
    repeat (3) begin
      cyc();
      chk("t2 addr", imemAddr, 32'd8);
      chk("t2 ifIdPc", ifIdPc, 32'd4);
      chk("t2 inst", ifIdInst, 32'hA4);
    end
    drive(1'b0, 32'd0, 1'b0);
    cyc();
    chk("t2 resume", imemAddr, 32'd12);
    // 3: redirect during stall, bit0 dropped
    drive(1'b1, 32'h41, 1'b1);
    #1 chk("t3 flush", {31'd0, flushIdEx}, 32'd1);
    cyc();
    chk("t3 pc", imemAddr, 32'h40);
    chk("t3 inst", ifIdInst, NOP);
    chk("t3 valid", {31'd0, ifIdValid}, 32'd0);
    chk("t3 cnt", redirectCount, 32'd1);
    chk("t3 mis", {31'd0, instMisaligned}, 32'd0);
    // 4: misaligned target traps
    drive(1'b1, 32'h206, 1'b0);
    cyc();
    chk("t4 pc", imemAddr, TVEC);
    chk("t4 mis", {31'd0, instMisaligned}, 32'd1);
    chk("t4 maddr", misalignAddr, 32'h206);
    chk("t4 valid", {31'd0, ifIdValid}, 32'd0);
    drive(1'b0, 32'd0, 1'b0);
    cyc();
    chk("t4 pulse", {31'd0, instMisaligned}, 32'd0);
    chk("t4 hold", misalignAddr, 32'h206);
    // 5: pc wrap
    drive(1'b1, 32'hFFFF_FFFC, 1'b0);
    cyc();
    chk("t5 pc", imemAddr, 32'hFFFF_FFFC);
    drive(1'b0, 32'd0, 1'b0);
    cyc();
    chk("t5 wrap", imemAddr, 32'd0);
    chk("t5 ifIdPc", ifIdPc, 32'hFFFF_FFFC);
    chk("t5 inc", ifIdPcInc, 32'd0);
    chk("t5 inst", ifIdInst, 32'h9C);
    // 6: async reset mid-redirect
    drive(1'b1, 32'h80, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t6 pc", imemAddr, RPC);
    chk("t6 inst", ifIdInst, NOP);
    chk("t6 cnt", redirectCount, 32'd0);
    chk("t6 flush", {31'd0, flushIdEx}, 32'd1);
    cyc();
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    cyc();
    chk("t6 ifIdPc", ifIdPc, RPC);
    chk("t6 addr", imemAddr, RPC + 4);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = t & 32'h0000_0FFF;
      drive($urandom_range(0, 4) == 0, t,
            $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 60) == 0) begin
        #2 rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else begin
        cyc();
      end
    end
    drive(1'b0, 32'd0, 1'b0);
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_stage.md
Name: fetch_redirect_stage

Overview:
- Instruction-fetch stage of the pipelined core.
- Holds the PC register and the IF/ID pipeline register, and drives the instruction-memory address.
- Consumes nextPcSrc and the branch/jump target from the branch unit in EX.
- On a taken redirect it reloads the PC, flushes IF/ID with a NOP bubble, and raises flushIdEx so ID/EX is also squashed. Misaligned targets are trapped to a fixed vector.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- TRAP_VEC, 32'h0000_0100, PC loaded when a redirect target is misaligned.
- NOP_INST, 32'h0000_0013, instruction word inserted into IF/ID on flush or reset (addi x0,x0,0).

Ports:
- clk  input  1  single core clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- nextPcSrc  input  1  from branch unit: 1 = redirect PC to brTarget this cycle.
- brTarget  input  32  redirect target computed in EX (ALU result).
- stall  input  1  from hazard unit: hold PC and IF/ID.
- imemAddr  output  32  instruction memory address (= pc, combinational).
- imemInst  input  32  instruction word at imemAddr, combinational read.
- ifIdInst  output  32  registered instruction to ID.
- ifIdPc  output  32  registered PC of ifIdInst.
- ifIdPcInc  output  32  registered ifIdPc+4.
- ifIdValid  output  1  1 = ifIdInst is a real fetched instruction, 0 = bubble.
- flushIdEx  output  1  combinational, = nextPcSrc; ID/EX loads a bubble next edge.
- instMisaligned  output  1  registered one-cycle pulse: last redirect target was misaligned.
- misalignAddr  output  32  registered offending target, held until the next misaligned redirect.
- redirectCount  output  32  registered count of accepted redirects, wraps mod 2^32.

Behaviour:
- Reset values (asynchronous, immediate on rst=1):
  - pc = RESET_PC
  - ifIdInst = NOP_INST, ifIdPc = 0, ifIdPcInc = 0, ifIdValid = 0
  - instMisaligned = 0, misalignAddr = 0, redirectCount = 0
- imemAddr = pc at all times. flushIdEx = nextPcSrc at all times (also during reset; consumers ignore it while rst=1).
- Per-edge update priority is redirect > stall > normal.
- Normal (nextPcSrc=0, stall=0):
  - pc <= pc+4
  - ifIdInst <= imemInst, ifIdPc <= pc, ifIdPcInc <= pc+4, ifIdValid <= 1
- Stall (nextPcSrc=0, stall=1): pc and all ifId* outputs hold.
- Redirect (nextPcSrc=1, stall ignored):
  - tgt = {brTarget[31:1],1'b0}; bit0 is always cleared (JALR rule).
  - If tgt[1]=0: pc <= tgt.
  - If tgt[1]=1: pc <= TRAP_VEC, instMisaligned <= 1, misalignAddr <= tgt.
  - IF/ID always flushed: ifIdInst <= NOP_INST, ifIdValid <= 0; ifIdPc and ifIdPcInc <= 0.
  - redirectCount <= redirectCount+1.
- instMisaligned is 0 on every edge that is not a misaligned redirect, so it is a single-cycle pulse. Back-to-back misaligned redirects keep it high for consecutive cycles.
- Arithmetic:
  - All adds are 32-bit and wrap: pc=32'hFFFF_FFFC, normal step -> pc=0, ifIdPcInc=0.
  - redirectCount wraps 32'hFFFF_FFFF -> 0.
- Redirect latency: target instruction address appears on imemAddr one cycle after nextPcSrc is sampled. The target instruction reaches ifIdInst two edges after that redirect.
- A redirect during a stall flushes and proceeds. The stall is not remembered.
- Reset asserted mid-redirect or mid-stall overrides everything. The first edge after rst deasserts performs a normal fetch from RESET_PC.
- No X propagation: imemInst X while stall=1 or during a redirect must not reach ifIdInst.

Test Plan:
1. Reset release, stall=0, nextPcSrc=0, imem returns 32'hA0+addr -> imemAddr 0,4,8 on successive cycles; ifIdPc lags by one (0,4); ifIdValid=1 from first edge; redirectCount=0.
2. At pc=8 hold stall=1 for 3 cycles -> pc stays 8, ifIdPc stays 4, ifIdInst unchanged; step resumes to pc=12 after stall drops.
3. nextPcSrc=1, brTarget=32'h0000_0041 with stall=1 in the same cycle -> flushIdEx=1 that cycle; next edge pc=32'h40, ifIdInst=NOP_INST, ifIdValid=0, redirectCount=1, instMisaligned=0.
4. nextPcSrc=1, brTarget=32'h0000_0206 -> pc=32'h100, instMisaligned=1 for exactly one cycle, misalignAddr=32'h206, IF/ID flushed.
5. Force pc to 32'hFFFF_FFFC via redirect, then run normal -> next pc=0, ifIdPc=32'hFFFF_FFFC, ifIdPcInc=0.
6. Assert rst asynchronously between edges while nextPcSrc=1 -> all outputs return to reset values immediately; after release, first fetch address is RESET_PC.
